// File: rtl/calc_operand_loader_pkg.sv
// Shared calculator definitions: loader FSM states, opcode width, nibble slots.
package calc_operand_loader_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned NUM_NIB = 4;

  // Nibble register slots, in key-entry order.
  localparam int unsigned NIB_A_HI = 0;
  localparam int unsigned NIB_A_LO = 1;
  localparam int unsigned NIB_B_HI = 2;
  localparam int unsigned NIB_B_LO = 3;

  typedef enum logic [2:0] {
    A_HI  = 3'd0,
    A_LO  = 3'd1,
    OP    = 3'd2,
    B_HI  = 3'd3,
    B_LO  = 3'd4,
    ISSUE = 3'd5,
    WAIT  = 3'd6
  } state_t;

endpackage

// File: rtl/calc_operand_loader_nibble_reg.sv
// 4-bit register with load enable; synchronous clear wins over load.
module nibble_reg
  import calc_operand_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q
);

  logic [NIB_W-1:0] q_q, q_d;

  // Next value: clear, else load, else hold.
  always_comb begin
    q_d = q_q;
    if (clr)     q_d = '0;
    else if (ld) q_d = d;
  end

  // Nibble storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/calc_operand_loader.sv
// Keypad operand loader: assembles A, Op, B from nibble strobes, then issues
// a one-cycle valueEn and holds the operands until the calculator is done.
module calc_operand_loader
  import calc_operand_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      key_in,
  input  logic            key_valid,
  input  logic            key_clr,
  input  logic            calc_done,
  output logic [7:0]      A,
  output logic [7:0]      B,
  output logic [OP_W-1:0] Op,
  output logic            valueEn,
  output logic            key_ready,
  output logic            err
);

  state_t state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic err_q, err_d;
  logic ven_q, ven_d;
  logic [NUM_NIB-1:0] nib_ld;
  logic [NUM_NIB-1:0][NIB_W-1:0] nib_q;

  // Key acceptance is a pure state decode; keys outside entry states are dropped.
  assign key_ready = (state_q == A_HI) || (state_q == A_LO) || (state_q == OP) ||
                     (state_q == B_HI) || (state_q == B_LO);

  // Next state, opcode/err update and nibble load selects. Clear overrides keys.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    ven_d   = 1'b0;
    nib_ld  = '0;
    if (key_clr) begin
      state_d = A_HI;
      op_d    = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        A_HI: if (key_valid) begin nib_ld[NIB_A_HI] = 1'b1; state_d = A_LO; end
        A_LO: if (key_valid) begin nib_ld[NIB_A_LO] = 1'b1; state_d = OP;   end
        OP: if (key_valid) begin
          if (key_in[3]) begin
            err_d = 1'b1;
          end else begin
            op_d    = key_in[OP_W-1:0];
            err_d   = 1'b0;
            state_d = B_HI;
          end
        end
        B_HI: if (key_valid) begin nib_ld[NIB_B_HI] = 1'b1; state_d = B_LO; end
        // valueEn is registered, so it rises on the same edge that enters ISSUE.
        B_LO: if (key_valid) begin
          nib_ld[NIB_B_LO] = 1'b1;
          state_d          = ISSUE;
          ven_d            = 1'b1;
        end
        ISSUE:   state_d = WAIT;
        WAIT:    if (calc_done) state_d = A_HI;
        default: state_d = A_HI;
      endcase
    end
  end

  // FSM state, opcode, sticky error and load pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A_HI;
      op_q    <= '0;
      err_q   <= 1'b0;
      ven_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ven_q   <= ven_d;
    end
  end

  for (genvar i = 0; i < NUM_NIB; i++) begin : g_nib
    nibble_reg u_nib (
      .clk (clk),
      .rst (rst),
      .clr (key_clr),
      .ld  (nib_ld[i]),
      .d   (key_in),
      .q   (nib_q[i])
    );
  end

  assign A       = {nib_q[NIB_A_HI], nib_q[NIB_A_LO]};
  assign B       = {nib_q[NIB_B_HI], nib_q[NIB_B_LO]};
  assign Op      = op_q;
  assign err     = err_q;
  assign valueEn = ven_q;

endmodule

// File: doc/calc_operand_loader.md
CALC_OPERAND_LOADER -- requirements
Module: calc_operand_loader

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single rising-edge clock.
REQ-003 The port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 The port key_in SHALL be an input, 4 bits wide: keypad nibble.
REQ-005 The port key_valid SHALL be an input, 1 bit wide: key_in is valid this cycle; it is a single-cycle strobe.
REQ-006 The port key_clr SHALL be an input, 1 bit wide: cancels the entry in progress.
REQ-007 The port calc_done SHALL be an input, 1 bit wide: the downstream calculator has consumed the operands.
REQ-008 The port A SHALL be an output, 8 bits wide: assembled operand A.
REQ-009 The port B SHALL be an output, 8 bits wide: assembled operand B.
REQ-010 The port Op SHALL be an output, 3 bits wide: assembled opcode.
REQ-011 The port valueEn SHALL be an output, 1 bit wide: a one-cycle load pulse that drives the calculator operand-register enable.
REQ-012 The port key_ready SHALL be an output, 1 bit wide: the block accepts keys this cycle.
REQ-013 The port err SHALL be an output, 1 bit wide: sticky flag indicating an illegal opcode key.

Function
REQ-014 The state machine SHALL have seven states, in this order: A_HI, A_LO, OP, B_HI, B_LO, ISSUE, WAIT.
REQ-015 In A_HI, a key_valid SHALL load A[7:4] from key_in and move to A_LO.
REQ-016 In A_LO, a key_valid SHALL load A[3:0] from key_in and move to OP.
REQ-017 In OP, a key_valid with key_in[3]=0 SHALL load Op from key_in[2:0], clear err and move to B_HI.
REQ-018 In OP, a key_valid with key_in[3]=1 SHALL set err, leave Op unchanged and stay in OP.
REQ-019 In B_HI, a key_valid SHALL load B[7:4] and move to B_LO; in B_LO, a key_valid SHALL load B[3:0] and move to ISSUE.
REQ-020 In ISSUE, valueEn SHALL be 1 for exactly one cycle, and the state SHALL move unconditionally to WAIT.
REQ-021 In WAIT, the block SHALL hold A, B and Op stable and return to A_HI on calc_done=1.
REQ-022 calc_done SHALL be ignored in every state other than WAIT.
REQ-023 key_ready SHALL be 1 in A_HI, A_LO, OP, B_HI and B_LO, and 0 in ISSUE and WAIT.
REQ-024 A key_valid while key_ready=0 SHALL be dropped, with no state or register change.
REQ-025 The latency from the B_LO key strobe to valueEn=1 SHALL be exactly 1 cycle, i.e. the next rising edge enters ISSUE.
REQ-026 A key_clr in any state SHALL, on the next edge, zero A, B, Op and err, and go to A_HI.
REQ-027 A simultaneous key_clr and key_valid SHALL resolve as clear, with the key dropped.
REQ-028 A key_clr in ISSUE SHALL take effect on the following edge, so the valueEn pulse in progress completes.
REQ-029 All outputs SHALL be registered, except key_ready, which SHALL be decoded from state.
REQ-030 Nibble assembly SHALL carry no arithmetic and no carry between nibbles; A and B are raw 8-bit concatenations.

Reset
REQ-031 While rst=1, regardless of clk, the state SHALL be A_HI and A, B, Op, valueEn and err SHALL be 0; key_ready=1 follows from the A_HI state.
REQ-032 A reset asserted mid-entry or in WAIT SHALL abandon the operation with no valueEn pulse.
REQ-033 After rst is released, the first clk edge SHALL accept a key.

Structure
REQ-034 The state encodings and the opcode width constant (3) SHALL live in the shared calculator package for reuse by the calculator datapath.
REQ-035 A single sub-module, nibble_reg (a 4-bit register with load enable and synchronous clear), SHALL be instantiated four times for A_hi, A_lo, B_hi and B_lo.
REQ-036 The rest of the block SHALL be one FSM with an Op/err register.

Verification
REQ-037 The bench SHALL cover a nominal entry: keys 0x3,0xC,0x2,0xA,0x5 on consecutive strobes -> A=0x3C, Op=3'b010, B=0xA5; valueEn high exactly one cycle after the 5th strobe; key_ready=0 until calc_done.
REQ-038 The bench SHALL cover an illegal op: keys 0x1,0x0,0x9, then 0x4 -> err=1 after 0x9 with the state still OP; after 0x4, err=0 and Op=3'b100.
REQ-039 The bench SHALL cover keys during WAIT: key 0xF is strobed in WAIT -> A, B and Op are unchanged and no second valueEn; calc_done=1 -> key_ready=1 next cycle.
REQ-040 The bench SHALL cover a simultaneous clear: key_clr=1 with key_valid=1 in B_LO -> A=B=0, Op=0, state A_HI, no valueEn.
REQ-041 The bench SHALL cover an asynchronous reset in WAIT: rst is pulsed between clk edges -> outputs are zero immediately; the next key 0x7 loads A[7:4]=0x7.
REQ-042 The bench SHALL cover a back-to-back operation: calc_done, then a full 5-key sequence -> a second valueEn carrying the new operands; the outputs during the first WAIT match the first entry.
